// File: rtl/pkt_header_match.sv
// First-beat Ethernet/IPv4/UDP header parser with a register match-action table keyed on UDP dport.
// Zero latency (outputs combinational from tdata and table state); never backpressures.
module pkt_header_match #(
    parameter int DATA_WIDTH     = 512,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int KEY_WIDTH      = 16,
    parameter int MAT_DEPTH      = 8,
    parameter int MAT_ADDR_WIDTH = 3,
    parameter int PRIO_WIDTH     = 8,
    parameter int CHAIN_WIDTH    = 32,
    parameter int TIME_WIDTH     = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int FLOW_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      config_mat_en,
    input  logic [MAT_ADDR_WIDTH-1:0] config_mat_addr,
    input  logic [KEY_WIDTH-1:0]      config_mat_key,
    input  logic [127:0]              config_mat_value,
    output logic [PRIO_WIDTH-1:0]     m_desc_prio,
    output logic [CHAIN_WIDTH-1:0]    m_desc_chain,
    output logic [TIME_WIDTH-1:0]     m_desc_time,
    output logic [LEN_WIDTH-1:0]      m_desc_pk_len,
    output logic [FLOW_WIDTH-1:0]     m_desc_flow_id,
    output logic                      m_desc_hit
);

    logic [MAT_DEPTH-1:0] valid_q, valid_d;
    logic [KEY_WIDTH-1:0] key_q   [MAT_DEPTH];
    logic [KEY_WIDTH-1:0] key_d   [MAT_DEPTH];
    logic [127:0]         value_q [MAT_DEPTH];
    logic [127:0]         value_d [MAT_DEPTH];

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < MAT_DEPTH; i++) begin
            key_d[i]   = key_q[i];
            value_d[i] = value_q[i];
        end
        if (config_mat_en) begin
            valid_d[config_mat_addr] = 1'b1;
            key_d[config_mat_addr]   = config_mat_key;
            value_d[config_mat_addr] = config_mat_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < MAT_DEPTH; i++) begin
                key_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < MAT_DEPTH; i++) begin
                key_q[i]   <= key_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

    // Fixed offsets assume an untagged Ethernet header and an option-less IPv4 header.
    logic [15:0] ethertype;
    logic [3:0]  ihl;
    logic [15:0] ip_total_len;
    logic [7:0]  protocol;
    logic [15:0] udp_dport;
    logic        is_ipv4;
    logic        eligible;

    assign ethertype    = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
    assign ihl          = s_axis_tdata[14*8 +: 4];
    assign ip_total_len = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
    assign protocol     = s_axis_tdata[23*8 +: 8];
    assign udp_dport    = {s_axis_tdata[36*8 +: 8], s_axis_tdata[37*8 +: 8]};
    assign is_ipv4      = (ethertype == 16'h0800);
    assign eligible     = is_ipv4 && (ihl == 4'd5) && (protocol == 8'd17);

    logic         hit;
    logic [127:0] win_value;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        win_value = '0;
        for (int i = MAT_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == KEY_WIDTH'(udp_dport))) begin
                hit       = 1'b1;
                win_value = value_q[i];
            end
        end
        if (!eligible) begin
            hit       = 1'b0;
            win_value = '0;
        end
    end

    always_comb begin
        m_desc_hit     = 1'b0;
        m_desc_chain   = '0;
        m_desc_time    = '0;
        m_desc_prio    = '0;
        m_desc_flow_id = '0;
        m_desc_pk_len  = '0;
        if (s_axis_tvalid) begin
            m_desc_hit     = hit;
            m_desc_chain   = CHAIN_WIDTH'(win_value[31:0]);
            m_desc_time    = TIME_WIDTH'(win_value[47:32]);
            m_desc_prio    = PRIO_WIDTH'(win_value[55:48]);
            m_desc_flow_id = FLOW_WIDTH'(win_value[71:56]);
            if (is_ipv4) begin
                m_desc_pk_len = LEN_WIDTH'(ip_total_len + 16'd14);
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tdata, win_value[127:72]};

endmodule

// File: tb/tb_pkt_header_match.sv
// Directed bench for pkt_header_match: table writes, lookup priority, eligibility, gating and reset.
module tb_pkt_header_match;

    logic         clk;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         config_mat_en;
    logic [2:0]   config_mat_addr;
    logic [15:0]  config_mat_key;
    logic [127:0] config_mat_value;
    logic [7:0]   m_desc_prio;
    logic [31:0]  m_desc_chain;
    logic [15:0]  m_desc_time;
    logic [15:0]  m_desc_pk_len;
    logic [15:0]  m_desc_flow_id;
    logic         m_desc_hit;

    int checks = 0;
    int errors = 0;

    pkt_header_match dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .config_mat_en   (config_mat_en),
        .config_mat_addr (config_mat_addr),
        .config_mat_key  (config_mat_key),
        .config_mat_value(config_mat_value),
        .m_desc_prio     (m_desc_prio),
        .m_desc_chain    (m_desc_chain),
        .m_desc_time     (m_desc_time),
        .m_desc_pk_len   (m_desc_pk_len),
        .m_desc_flow_id  (m_desc_flow_id),
        .m_desc_hit      (m_desc_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {hit, prio, chain, time, pk_len, flow_id}
    logic [88:0] obs;
    assign obs = {m_desc_hit, m_desc_prio, m_desc_chain, m_desc_time, m_desc_pk_len, m_desc_flow_id};

    function automatic logic [88:0] desc(input logic h, input logic [7:0] p, input logic [31:0] c,
                                         input logic [15:0] t, input logic [15:0] l, input logic [15:0] f);
        return {h, p, c, t, l, f};
    endfunction

    function automatic logic [511:0] beat(input logic [15:0] eth, input logic [3:0] ihl,
                                          input logic [7:0] proto, input logic [15:0] tlen,
                                          input logic [15:0] dport);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 12; i++) b[i*8 +: 8] = 8'hA0 + 8'(i);
        b[12*8 +: 8] = eth[15:8];
        b[13*8 +: 8] = eth[7:0];
        b[14*8 +: 8] = {4'h4, ihl};
        b[16*8 +: 8] = tlen[15:8];
        b[17*8 +: 8] = tlen[7:0];
        b[23*8 +: 8] = proto;
        b[34*8 +: 8] = 8'hC0;
        b[36*8 +: 8] = dport[15:8];
        b[37*8 +: 8] = dport[7:0];
        b[38*8 +: 8] = 8'h77;
        return b;
    endfunction

    function automatic logic [127:0] val(input logic [31:0] c, input logic [15:0] t,
                                         input logic [7:0] p, input logic [15:0] f);
        return {56'hDEAD_BEEF_0123_45, f, p, t, c};
    endfunction

    task automatic write_entry(input logic [2:0] a, input logic [15:0] k, input logic [127:0] v);
        @(negedge clk);
        config_mat_en    = 1'b1;
        config_mat_addr  = a;
        config_mat_key   = k;
        config_mat_value = v;
        @(posedge clk);
        #1;
        config_mat_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0)) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0));
        end
        @(negedge clk);
        rst = 1'b1;
        s_axis_tdata  = beat(16'h0800, 4'd5, 8'd17, 16'h002E, 16'h1234);
        s_axis_tvalid = 1'b1;
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL empty_miss got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
    endtask

    task automatic test_write_hit;
        // Beat is on the bus during the write cycle: old contents must be seen.
        @(negedge clk);
        config_mat_en    = 1'b1;
        config_mat_addr  = 3'd2;
        config_mat_key   = 16'h1234;
        config_mat_value = val(32'h3, 16'h0010, 8'h05, 16'h0042);
        s_axis_tdata     = beat(16'h0800, 4'd5, 8'd17, 16'h002E, 16'h1234);
        s_axis_tvalid    = 1'b1;
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL same_cycle_write got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
        @(posedge clk);
        #1;
        config_mat_en = 1'b0;
        checks++;
        if (obs !== desc(1'b1, 8'h05, 32'h3, 16'h0010, 16'd60, 16'h0042)) begin
            errors++;
            $display("FAIL hit_after_write got %h want %h", obs, desc(1'b1, 8'h05, 32'h3, 16'h0010, 16'd60, 16'h0042));
        end
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd17, 16'h002E, 16'h1235);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL other_port_miss got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
    endtask

    task automatic test_ineligible;
        s_axis_tdata = beat(16'h86DD, 4'd5, 8'd17, 16'h002E, 16'h1234);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0)) begin
            errors++;
            $display("FAIL ethertype_ipv6 got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0));
        end
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd6, 16'h0100, 16'h1234);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h010E, 16'h0)) begin
            errors++;
            $display("FAIL proto_tcp got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h010E, 16'h0));
        end
        s_axis_tdata = beat(16'h0800, 4'd6, 8'd17, 16'h002E, 16'h1234);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL ihl_6 got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
    endtask

    task automatic test_duplicate_key;
        write_entry(3'd5, 16'h0050, val(32'h9, 16'h0001, 8'h01, 16'h0005));
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd17, 16'h0014, 16'h0050);
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h01, 32'h9, 16'h0001, 16'd34, 16'h0005)) begin
            errors++;
            $display("FAIL dup_single got %h want %h", obs, desc(1'b1, 8'h01, 32'h9, 16'h0001, 16'd34, 16'h0005));
        end
        write_entry(3'd0, 16'h0050, val(32'h7, 16'h0002, 8'h02, 16'h0006));
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h02, 32'h7, 16'h0002, 16'd34, 16'h0006)) begin
            errors++;
            $display("FAIL dup_lowest_wins got %h want %h", obs, desc(1'b1, 8'h02, 32'h7, 16'h0002, 16'd34, 16'h0006));
        end
        write_entry(3'd0, 16'h0051, val(32'h7, 16'h0002, 8'h02, 16'h0006));
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h01, 32'h9, 16'h0001, 16'd34, 16'h0005)) begin
            errors++;
            $display("FAIL dup_overwrite got %h want %h", obs, desc(1'b1, 8'h01, 32'h9, 16'h0001, 16'd34, 16'h0005));
        end
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd17, 16'h0014, 16'h0051);
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h02, 32'h7, 16'h0002, 16'd34, 16'h0006)) begin
            errors++;
            $display("FAIL overwrite_new_key got %h want %h", obs, desc(1'b1, 8'h02, 32'h7, 16'h0002, 16'd34, 16'h0006));
        end
    endtask

    task automatic test_gating_and_wrap;
        s_axis_tdata  = beat(16'h0800, 4'd5, 8'd17, 16'h002E, 16'h1234);
        s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0)) begin
            errors++;
            $display("FAIL tvalid_low got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'h0, 16'h0));
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(16'h0800, 4'd5, 8'd17, 16'hFFFA, 16'h1234);
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h05, 32'h3, 16'h0010, 16'h0008, 16'h0042)) begin
            errors++;
            $display("FAIL len_wrap got %h want %h", obs, desc(1'b1, 8'h05, 32'h3, 16'h0010, 16'h0008, 16'h0042));
        end
    endtask

    task automatic test_reset_midstream;
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd17, 16'h002E, 16'h1234);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL reset_midstream got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0)) begin
            errors++;
            $display("FAIL after_reset_miss got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd60, 16'h0));
        end
        s_axis_tdata = beat(16'h0800, 4'd5, 8'd17, 16'h0014, 16'h0050);
        #1;
        checks++;
        if (obs !== desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd34, 16'h0)) begin
            errors++;
            $display("FAIL after_reset_miss2 got %h want %h", obs, desc(1'b0, 8'h0, 32'h0, 16'h0, 16'd34, 16'h0));
        end
        write_entry(3'd7, 16'h0050, val(32'hCAFE, 16'h0003, 8'h0A, 16'h0BEE));
        #1;
        checks++;
        if (obs !== desc(1'b1, 8'h0A, 32'hCAFE, 16'h0003, 16'd34, 16'h0BEE)) begin
            errors++;
            $display("FAIL rewrite_hit got %h want %h", obs, desc(1'b1, 8'h0A, 32'hCAFE, 16'h0003, 16'd34, 16'h0BEE));
        end
    endtask

    initial begin
        rst              = 1'b1;
        s_axis_tdata     = '0;
        s_axis_tkeep     = '1;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b1;
        config_mat_en    = 1'b0;
        config_mat_addr  = '0;
        config_mat_key   = '0;
        config_mat_value = '0;
        #2;
        test_reset();
        test_write_hit();
        test_ineligible();
        test_duplicate_key();
        test_gating_and_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
